exec_unit: RTL and testbench

Multi-cycle execute stage directly downstream of the register bank. Captures the two read operands (`dr1`/`dr2`) on a start strobe and computes one of eight operations, including an iterative 32-cycle multiply. It then issues a single-cycle writeback (`we`/`aw`/`dataIn`) back into the register bank. Operands are latched, so the bank's read addresses and write port are free while the unit is busy.

---
 rtl/exec_pkg.sv | 25 ++
 rtl/exec_unit_mul.sv | 65 ++++++
 rtl/exec_unit.sv | 124 ++++++++++++
 tb/tb_exec_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage and the register bank it feeds:
// default widths, operation codes and the execute FSM state encoding.
package exec_pkg;

   localparam int WIDTH_DEF   = 32;
   localparam int AWIDTH_DEF  = 5;
   localparam int MUL_CNT_W   = 5;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b100;
   localparam logic [2:0] OP_NOR = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_RSV = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_WB   = 2'd3
   } state_e;

endpackage

// File: rtl/exec_unit_mul.sv
// Iterative shift-add multiplier: one multiplier bit per step, 32 steps.
// Produces the low WIDTH bits of the unsigned product. acc_next is the
// accumulator value including the current step, so the caller can capture
// the finished product on the same edge as the final step.
module mul_iter
   import exec_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] mcand,
   input  logic [WIDTH-1:0] mplier,
   output logic [WIDTH-1:0] acc_next,
   output logic             last
);

   logic [WIDTH-1:0]     mcand_q,  mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     acc_q,    acc_d;
   logic [MUL_CNT_W-1:0] cnt_q,    cnt_d;

   // Partial-product add for the current multiplier bit.
   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last     = (cnt_q == MUL_CNT_W'(31));

   // Next-state for the multiplier datapath: load wins over step.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (load) begin
         mcand_d  = mcand;
         mplier_d = mplier;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         acc_d    = acc_next;
         cnt_d    = cnt_q + MUL_CNT_W'(1);
      end
   end

   // Multiplier state registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (rst) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/exec_unit.sv
// Multi-cycle execute stage. Latches operands on start, computes a single-cycle
// ALU op or a 32-step multiply, then issues one writeback cycle to the bank.
module exec_unit
   import exec_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int AWIDTH = AWIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic [AWIDTH-1:0] dest,
   output logic              busy,
   output logic              done,
   output logic              we,
   output logic [AWIDTH-1:0] aw,
   output logic [WIDTH-1:0]  dataOut,
   output logic              zero
);

   state_e state_q, state_d;

   logic [WIDTH-1:0]  a_q, b_q;
   logic [2:0]        op_q;
   logic [AWIDTH-1:0] dest_q;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [WIDTH-1:0]  alu_res;
   logic [WIDTH-1:0]  mul_sum;
   logic              mul_load, mul_step, mul_last;
   logic              accept;

   // A request is only seen in IDLE; starts while busy are dropped.
   assign accept   = (state_q == ST_IDLE) && start;
   assign mul_load = accept && (op == OP_MUL);
   assign mul_step = (state_q == ST_MUL);

   mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk      (clk),
      .rst      (rst),
      .load     (mul_load),
      .step     (mul_step),
      .mcand    (a),
      .mplier   (b),
      .acc_next (mul_sum),
      .last     (mul_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = (op == OP_MUL) ? ST_MUL : ST_EXEC;
         ST_EXEC: state_d = ST_WB;
         ST_MUL:  if (mul_last) state_d = ST_WB;
         ST_WB:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from the registered state only.
   always_comb begin
      busy = (state_q != ST_IDLE);
      we   = (state_q == ST_WB);
      done = (state_q == ST_WB);
   end

   // Operand, op and destination latches, loaded once per accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_AND;
         dest_q <= '0;
      end else if (accept) begin
         a_q    <= a;
         b_q    <= b;
         op_q   <= op;
         dest_q <= dest;
      end
   end

   // Single-cycle ALU on the latched operands.
   always_comb begin
      alu_res = '0;
      unique case (op_q)
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_ADD:  alu_res = a_q + b_q;
         OP_SUB:  alu_res = a_q - b_q;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
         OP_NOR:  alu_res = ~(a_q | b_q);
         default: alu_res = '0;  // MUL never reaches EXEC; reserved yields 0
      endcase
   end

   // Result capture: ALU result in EXEC, finished product on the last MUL step.
   always_comb begin
      result_d = result_q;
      if (state_q == ST_EXEC)               result_d = alu_res;
      else if (state_q == ST_MUL && mul_last) result_d = mul_sum;
   end

   // Result register.
   always_ff @(posedge clk) begin
      if (rst) result_q <= '0;
      else     result_q <= result_d;
   end

   assign aw      = dest_q;
   assign dataOut = result_q;
   assign zero    = (result_q == '0);

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: directed vector table, hand-written
// multi-cycle sequences, and random ops against a behavioural model.
module tb_exec_unit;
   import exec_pkg::*;

   logic        clk, rst, start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic [4:0]  dest;
   logic        busy, done, we, zero;
   logic [4:0]  aw;
   logic [31:0] dataOut;

   int n_vec = 0;
   int n_err = 0;

   exec_unit #(.WIDTH(32), .AWIDTH(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .dest    (dest),
      .busy    (busy),
      .done    (done),
      .we      (we),
      .aw      (aw),
      .dataOut (dataOut),
      .zero    (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dest;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Behavioural model: result straight from the operation definitions.
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint unsigned p;
      case (o)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return x + y;
         3'd3: return x - y;
         3'd4: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         3'd5: return ~(x | y);
         3'd6: begin
            p = longint'(x) * longint'(y);
            return p[31:0];
         end
         default: return 32'd0;
      endcase
   endfunction

   // Issue one op from a negedge, scramble inputs after acceptance, wait for
   // the writeback (bounded) and check it. Returns at the negedge after WB.
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] d,
                         input logic [31:0] exp, input int exp_lat);
      int lat;
      int busy_cycles;
      start = 1'b1; op = o; a = x; b = y; dest = d;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; op = 3'($urandom_range(7, 0)); dest = 5'($urandom_range(31, 0));
      lat = 1;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy) busy_cycles++;
         if (done) break;
         @(negedge clk);
         lat++;
      end
      check({name, " done_seen"}, 32'(done), 32'd1);
      check({name, " we"},        32'(we), 32'd1);
      check({name, " latency"},   32'(lat), 32'(exp_lat));
      check({name, " busy_cyc"},  32'(busy_cycles), 32'(exp_lat));
      check({name, " aw"},        32'(aw), 32'(d));
      check({name, " dataOut"},   dataOut, exp);
      check({name, " zero"},      32'(zero), (exp == 32'd0) ? 32'd1 : 32'd0);
      @(negedge clk);
      check({name, " done_pulse"}, 32'(done), 32'd0);
      check({name, " idle"},       32'(busy), 32'd0);
   endtask

   vec_t vecs[12];
   int   we_cnt;
   logic [31:0] got;
   logic [4:0]  got_aw;
   logic [2:0]  r_op;
   logic [31:0] r_a, r_b;
   logic [4:0]  r_d;

   initial begin
      vecs[0]  = '{"add",     OP_ADD, 32'd100,        32'd200,        5'd3,  32'd300,        2};
      vecs[1]  = '{"sub_eq",  OP_SUB, 32'd5,          32'd5,          5'd4,  32'd0,          2};
      vecs[2]  = '{"sub_wrap",OP_SUB, 32'd0,          32'd1,          5'd5,  32'hFFFF_FFFF,  2};
      vecs[3]  = '{"slt_neg", OP_SLT, 32'hFFFF_FFFF,  32'd1,          5'd6,  32'd1,          2};
      vecs[4]  = '{"slt_pos", OP_SLT, 32'd1,          32'hFFFF_FFFF,  5'd7,  32'd0,          2};
      vecs[5]  = '{"and",     OP_AND, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  5'd8,  32'h00F0_00F0,  2};
      vecs[6]  = '{"or",      OP_OR,  32'hF0F0_F0F0,  32'h0FF0_0FF0,  5'd9,  32'hFFF0_FFF0,  2};
      vecs[7]  = '{"nor",     OP_NOR, 32'hF0F0_F0F0,  32'h0FF0_0FF0,  5'd10, 32'h000F_000F,  2};
      vecs[8]  = '{"mul",     OP_MUL, 32'd1000,       32'd3000,       5'd11, 32'd3000000,    33};
      vecs[9]  = '{"mul_wrap",OP_MUL, 32'hFFFF_FFFF,  32'd2,          5'd12, 32'hFFFF_FFFE,  33};
      vecs[10] = '{"rsv",     OP_RSV, 32'h1234_5678,  32'h9ABC_DEF0,  5'd13, 32'd0,          2};
      vecs[11] = '{"dest0",   OP_ADD, 32'd1,          32'd1,          5'd0,  32'd2,          2};

      rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; dest = '0;
      repeat (3) @(negedge clk);
      check("rst busy",    32'(busy), 32'd0);
      check("rst done",    32'(done), 32'd0);
      check("rst we",      32'(we), 32'd0);
      check("rst aw",      32'(aw), 32'd0);
      check("rst dataOut", dataOut, 32'd0);
      check("rst zero",    32'(zero), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // Directed table; each op starts in the cycle right after the previous
      // done, which also exercises back-to-back acceptance.
      for (int i = 0; i < 12; i++)
         run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].exp, vecs[i].lat);

      // MUL with a stray ADD start at cycle 5: exactly one writeback, MUL result.
      start = 1'b1; op = OP_MUL; a = 32'd7; b = 32'd9; dest = 5'd4;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd2; dest = 5'd9;
      @(negedge clk);
      start = 1'b0;
      we_cnt = 0; got = '0; got_aw = '0;
      for (int i = 0; i < 45; i++) begin
         if (we) begin
            we_cnt++;
            got = dataOut;
            got_aw = aw;
         end
         @(negedge clk);
      end
      check("stray we_count", 32'(we_cnt), 32'd1);
      check("stray dataOut",  got, 32'd63);
      check("stray aw",       32'(got_aw), 32'd4);

      // Reset during cycle 10 of a MUL: abort, no writeback ever.
      start = 1'b1; op = OP_MUL; a = 32'd1000; b = 32'd3000; dest = 5'd20;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst busy",    32'(busy), 32'd0);
      check("midrst we",      32'(we), 32'd0);
      check("midrst aw",      32'(aw), 32'd0);
      check("midrst dataOut", dataOut, 32'd0);
      check("midrst zero",    32'(zero), 32'd1);
      rst = 1'b0;
      we_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         if (we) we_cnt++;
         @(negedge clk);
      end
      check("midrst no_we", 32'(we_cnt), 32'd0);
      run_op("post_rst_add", OP_ADD, 32'd7, 32'd8, 5'd1, 32'd15, 2);

      // Start raised during WB is ignored.
      start = 1'b1; op = OP_AND; a = 32'hF; b = 32'h3; dest = 5'd2;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (done) break;
         @(negedge clk);
      end
      check("wbstart done",    32'(done), 32'd1);
      check("wbstart dataOut", dataOut, 32'd3);
      start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1; dest = 5'd3;
      @(negedge clk);
      start = 1'b0;
      check("wbstart ignored", 32'(busy), 32'd0);
      we_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (we) we_cnt++;
         @(negedge clk);
      end
      check("wbstart no_we", 32'(we_cnt), 32'd0);

      // Random ops against the behavioural model.
      for (int i = 0; i < 20; i++) begin
         r_op = 3'($urandom_range(7, 0));
         r_a  = $urandom;
         r_b  = $urandom;
         r_d  = 5'($urandom_range(31, 0));
         if (i % 4 == 0) r_b = r_a;
         run_op("rand", r_op, r_a, r_b, r_d, model(r_op, r_a, r_b), (r_op == OP_MUL) ? 33 : 2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
